// File: rtl/div_pkg.sv
// div_pkg: definitions shared by the divider and its operand dispatcher.
//   DIV_N               default operand/quotient width, must match the divider
//   S_IDLE/S_WAIT/S_OUT dispatcher FSM state encoding (2 bits)
package div_pkg;
  localparam int DIV_N = 16;

  localparam logic [1:0] S_IDLE = 2'd0;  // waiting for a queued request
  localparam logic [1:0] S_WAIT = 2'd1;  // request issued, waiting for done
  localparam logic [1:0] S_OUT  = 2'd2;  // result presented, waiting for ready
endpackage

// File: rtl/div_dispatch_fifo.sv
// div_dispatch_fifo: synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst        clock, synchronous active-high reset (flushes the FIFO)
//   push_i, wdata_i write request and data; ignored while full
//   pop_i           read request; ignored while empty
//   rdata_o         head entry, shown combinationally
//   full_o, empty_o status derived from the registered pointers
module div_dispatch_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit tells a full FIFO apart from an empty one.
  logic [AW:0]  wptr_q, rptr_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/div_dispatch.sv
// div_dispatch: buffers tagged division requests and issues them one at a
// time to the sign-magnitude divider, returning quotients in request order.
// Optional build macro: DIV_DISPATCH_DZ_BYPASS_EN -- zero divisors are
// answered locally (quotient 0, out_dz=1) without starting the divider.
// Ports:
//   clk, rst                               clock, synchronous active-high reset
//   in_valid/in_ready, in_dividend,
//   in_divisor, in_tag                     request stream
//   div_start, div_dividend, div_divisor   issue port to the divider (registered)
//   div_busy, div_done, div_quotient       divider status/result
//   out_valid/out_ready, out_quotient,
//   out_tag [, out_dz]                     result stream
// Handshakes: a transfer happens on a rising clk edge where valid && ready;
// a source holding valid keeps its payload stable until that edge.
module div_dispatch
  import div_pkg::*;
#(
  parameter int N     = DIV_N,
  parameter int TW    = 4,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_dividend,
  input  logic [N-1:0]  in_divisor,
  input  logic [TW-1:0] in_tag,
  output logic          div_start,
  output logic [N-1:0]  div_dividend,
  output logic [N-1:0]  div_divisor,
  input  logic          div_busy,
  input  logic          div_done,
  input  logic [N-1:0]  div_quotient,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_quotient,
  output logic [TW-1:0] out_tag
`ifdef DIV_DISPATCH_DZ_BYPASS_EN
  ,
  output logic          out_dz
`endif
);
  localparam int FW = 2 * N + TW;

  logic          fifo_full, fifo_empty, fifo_pop;
  logic [FW-1:0] fifo_head;
  logic [N-1:0]  head_dividend, head_divisor;
  logic [TW-1:0] head_tag;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tag_q, tag_d;
  logic          start_q, start_d;
  logic [N-1:0]  dvd_q, dvd_d, dvs_q, dvs_d, quo_q, quo_d;
  logic [TW-1:0] otag_q, otag_d;
  logic          oval_q, oval_d;
`ifdef DIV_DISPATCH_DZ_BYPASS_EN
  logic          dz_q, dz_d;
`endif

  div_dispatch_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .wdata_i ({in_dividend, in_divisor, in_tag}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign {head_dividend, head_divisor, head_tag} = fifo_head;

  assign in_ready     = !fifo_full;
  assign div_start    = start_q;
  assign div_dividend = dvd_q;
  assign div_divisor  = dvs_q;
  assign out_valid    = oval_q;
  assign out_quotient = quo_q;
  assign out_tag      = otag_q;
`ifdef DIV_DISPATCH_DZ_BYPASS_EN
  assign out_dz       = dz_q;
`endif

  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    start_d  = 1'b0;  // start is a single-cycle pulse
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    quo_d    = quo_q;
    otag_d   = otag_q;
    oval_d   = oval_q;
    fifo_pop = 1'b0;
`ifdef DIV_DISPATCH_DZ_BYPASS_EN
    dz_d     = dz_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty && !div_busy) begin
          fifo_pop = 1'b1;
`ifdef DIV_DISPATCH_DZ_BYPASS_EN
          if (head_divisor == '0) begin
            quo_d   = '0;
            dz_d    = 1'b1;
            otag_d  = head_tag;
            oval_d  = 1'b1;
            state_d = S_OUT;
          end else begin
`endif
            dvd_d   = head_dividend;
            dvs_d   = head_divisor;
            tag_d   = head_tag;
            start_d = 1'b1;
            state_d = S_WAIT;
`ifdef DIV_DISPATCH_DZ_BYPASS_EN
          end
`endif
        end
      end
      S_WAIT: begin
        if (div_done) begin
          quo_d   = div_quotient;
          otag_d  = tag_q;
          oval_d  = 1'b1;
`ifdef DIV_DISPATCH_DZ_BYPASS_EN
          dz_d    = 1'b0;
`endif
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          oval_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tag_q   <= '0;
      start_q <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      otag_q  <= '0;
      oval_q  <= 1'b0;
`ifdef DIV_DISPATCH_DZ_BYPASS_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      start_q <= start_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      otag_q  <= otag_d;
      oval_q  <= oval_d;
`ifdef DIV_DISPATCH_DZ_BYPASS_EN
      dz_q    <= dz_d;
`endif
    end
  end
endmodule

// File: tb/tb_div_dispatch.sv
// tb_div_dispatch: bench for div_dispatch with a behavioural divider model,
// an expected-result queue filled at request acceptance and a monitor that
// checks each result handshake against it.
module tb_div_dispatch;
  localparam int N     = 16;
  localparam int TW    = 4;
  localparam int DEPTH = 4;
  localparam int EW    = TW + N + 1;
  localparam int LAT   = 6;
`ifdef DIV_DISPATCH_DZ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0, in_ready;
  logic [N-1:0]  in_dividend = '0, in_divisor = '0;
  logic [TW-1:0] in_tag = '0;
  logic          div_start;
  logic [N-1:0]  div_dividend, div_divisor;
  logic          out_valid, out_ready = 1'b0;
  logic [N-1:0]  out_quotient;
  logic [TW-1:0] out_tag;
  logic          dz_obs;

  // ---------------- divider model ----------------
  logic                m_busy, m_done;
  logic [N-1:0]        m_q;
  logic signed [N-1:0] m_a, m_b;
  int                  m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_q <= '0; m_cnt <= 0; m_a <= '0; m_b <= '0;
    end else begin
      m_done <= 1'b0;
      if (div_start && !m_busy) begin
        if (div_divisor == '0) begin
          m_q <= '0; m_done <= 1'b1;
        end else begin
          m_busy <= 1'b1; m_cnt <= LAT; m_a <= div_dividend; m_b <= div_divisor;
        end
      end else if (m_busy) begin
        if (m_cnt == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1; m_q <= m_a / m_b;
        end
        m_cnt <= m_cnt - 1;
      end
    end
  end

`ifdef DIV_DISPATCH_DZ_BYPASS_EN
  logic out_dz;
  assign dz_obs = out_dz;
`else
  assign dz_obs = 1'b0;
`endif

  div_dispatch #(.N(N), .TW(TW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_dividend  (in_dividend),
    .in_divisor   (in_divisor),
    .in_tag       (in_tag),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_busy     (m_busy),
    .div_done     (m_done),
    .div_quotient (m_q),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_quotient (out_quotient),
    .out_tag      (out_tag)
`ifdef DIV_DISPATCH_DZ_BYPASS_EN
    ,
    .out_dz       (out_dz)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int chk_cnt = 0, pass_cnt = 0;
  int start_cnt = 0, outstanding = 0;
  bit rand_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int ref_div(input int a, input int b);
    int ma, mb, m;
    if (b == 0) return 0;
    ma = (a < 0) ? -a : a;
    mb = (b < 0) ? -b : b;
    m  = ma / mb;
    return ((a < 0) != (b < 0)) ? -m : m;
  endfunction

  // Monitor: sampled on the falling edge, between active edges.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst) begin
      outstanding = 0;
    end else begin
      if (div_start) begin
        start_cnt++;
        chk("one_start_per_done", outstanding, 0);
        outstanding++;
      end
      if (m_done && outstanding > 0) outstanding--;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_result: got tag %0d q %0h with nothing expected", out_tag, out_quotient);
        end else begin
          e = exp_q.pop_front();
          chk("result{tag,q,dz}", {out_tag, out_quotient, dz_obs}, e);
        end
      end
    end
  end

  // Random result back-pressure.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_en) out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int a, input int b, input int t, input int q, input bit dz);
    int n;
    in_valid = 1'b1; in_dividend = a[N-1:0]; in_divisor = b[N-1:0]; in_tag = t[TW-1:0];
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({t[TW-1:0], q[N-1:0], dz});
        break;
      end
      n++;
      if (n > 300) begin
        chk_cnt++;
        $display("FAIL send_timeout: in_ready stayed 0 for tag %0d", t);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (exp_q.size() != 0) begin
      chk_cnt++;
      $display("FAIL drain_timeout: %0d results still expected", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int s0, a, b;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {div_start, div_dividend, div_divisor, out_valid, out_quotient, out_tag, dz_obs}, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // Single request: exactly one start pulse.
    s0 = start_cnt;
    send(100, 7, 3, 14, 1'b0);
    drain();
    chk("single_starts", start_cnt - s0, 1);

    // Sign combinations, tags in order.
    send(-100, 7, 0, -14, 1'b0);
    send(100, -7, 1, -14, 1'b0);
    send(-100, -7, 2, 14, 1'b0);
    send(100, 7, 3, 14, 1'b0);
    drain();

    // Burst against a stalled result port: 1 in flight + DEPTH queued.
    out_ready = 1'b0;
    send(50, 5, 4, 10, 1'b0);
    send(77, -8, 5, -9, 1'b0);
    send(-1000, 33, 6, -30, 1'b0);
    send(32767, 2, 7, 16383, 1'b0);
    send(-32767, 4, 8, -8191, 1'b0);
    in_valid = 1'b1; in_dividend = 16'd1; in_divisor = 16'd3; in_tag = 4'd9;
    repeat (10) @(negedge clk);
    chk("burst_full_in_ready", in_ready, 0);
    chk("burst_out_valid_held", out_valid, 1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(1, 3, 9, 0, 1'b0);
    drain();

    // Zero divisor.
    s0 = start_cnt;
    send(5, 0, 10, 0, BYP);
    drain();
    chk("dz_starts", start_cnt - s0, BYP ? 0 : 1);

    // Reset while waiting on the divider with two requests queued.
    send(1000, 10, 11, 100, 1'b0);
    send(20, 4, 12, 5, 1'b0);
    send(30, 6, 13, 5, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_outputs", {div_start, div_dividend, div_divisor, out_valid, out_quotient, out_tag, dz_obs}, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    send(9, 3, 14, 3, 1'b0);
    drain();

    // Random operands under random back-pressure.
    rand_en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      a = int'($urandom_range(0, 65534)) - 32767;
      b = int'($urandom_range(0, 600)) - 300;
      send(a, b, i % 16, ref_div(a, b), BYP && (b == 0));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rand_en = 1'b0;
    #1;
    out_ready = 1'b1;
    drain();
    chk("final_in_ready", in_ready, 1);
    chk("final_out_valid", out_valid, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/div_dispatch.md
# div_dispatch

Operand dispatcher that sits directly upstream of the sign-magnitude binary-search divider. It accepts tagged division requests on a valid/ready stream, buffers them in a small FIFO, and issues them one at a time to the divider's start/dividend/divisor port. It captures the divider's quotient on its `done` pulse and returns it with the original tag on a valid/ready result stream, in request order.

## Interface
- `N`, 16: operand and quotient width (two's complement); must match the divider.
- `TW`, 4: request tag width.
- `DEPTH`, 4: request FIFO depth; power of two, ≥ 2.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: request valid.
- `in_ready` out 1: request accepted when `in_valid && in_ready`.
- `in_dividend` in N: signed dividend.
- `in_divisor` in N: signed divisor.
- `in_tag` in TW: request tag.
- `div_start` out 1: one-cycle start pulse to the divider.
- `div_dividend` out N: registered dividend to the divider.
- `div_divisor` out N: registered divisor to the divider.
- `div_busy` in 1: divider busy.
- `div_done` in 1: divider completion pulse.
- `div_quotient` in N: divider result, valid with `div_done`.
- `out_valid` out 1: result valid.
- `out_ready` in 1: result consumed when `out_valid && out_ready`.
- `out_quotient` out N: signed quotient.
- `out_tag` out TW: tag of the request.
- `out_dz` out 1: divide-by-zero flag; present only with `DIV_DISPATCH_DZ_BYPASS_EN`.

## Operation
- FIFO stores {dividend, divisor, tag}. `in_ready = !full`. Writes when full are not accepted. Pop happens only in S_IDLE.
- At most one request is outstanding at the divider. Results return strictly in FIFO order.
- States (2-bit):
  - S_IDLE: if `!empty && !div_busy`: pop the head, load `div_dividend`/`div_divisor`, set `div_start<=1`, latch tag, go to S_WAIT.
  - S_WAIT: `div_start<=0`. On `div_done`: `out_quotient<=div_quotient`, `out_tag<=` latched tag, `out_valid<=1`, go to S_OUT.
  - S_OUT: hold the outputs. On `out_ready`: `out_valid<=0`, go to S_IDLE.
- Quotient semantics are the divider's: truncation toward zero; divisor 0 gives quotient 0.
- `div_done` outside S_WAIT is ignored.
- Reset:
  - All outputs 0, except `in_ready`, which is 1 after reset (FIFO empty).
  - FIFO flushed, state S_IDLE, latched tag 0.
  - A reset mid-operation discards the queued requests and the request in flight. The divider shares `rst`, so both sides return to idle on the same edge.

## Timing
- Request accepted at edge k is written to the FIFO. The earliest pop is at edge k+1, with `div_start` high during cycle k+1 to k+2.
- A simultaneous push and pop in S_IDLE is allowed. Occupancy is unchanged; `in_ready` follows the registered full flag.
- `out_valid` rises on the edge after `div_done`. Earliest re-issue is the cycle after the result handshake, so `out_ready` held high costs 1 bubble cycle per result.
- Divide-by-zero through the divider: `div_done` arrives 1 cycle after `div_start` is sampled.
- Back-pressure: `out_ready` low holds S_OUT indefinitely. The FIFO keeps accepting until full.

## Configuration
- `DIV_DISPATCH_DZ_BYPASS_EN` defined:
  - In S_IDLE, a head with divisor 0 is popped without asserting `div_start`.
  - Outputs go directly to `out_quotient=0`, `out_dz=1`, `out_valid=1`, and the state moves to S_OUT.
  - `out_dz` is 0 for all other results.
- Not defined: zero divisors are issued to the divider like any other request, and there is no `out_dz` port.

## Structure
- Shared package `div_pkg`: state encoding localparams (S_IDLE, S_WAIT, S_OUT) and the default N shared with the divider.
- Sub-module `div_dispatch_fifo`:
  - Synchronous FIFO parameterised by width and DEPTH.
  - log2(DEPTH)+1-bit read/write pointers; full/empty derived from the pointer MSB compare.
  - Head data shown combinationally (first-word fall-through).

## Test plan
- Single request 100/7, tag 3, `out_ready=1` → `div_start` pulse once; result 14, tag 3.
- Signs: -100/7 → -14; 100/-7 → -14; -100/-7 → 14. Tags 0..3 returned in order.
- Burst of 6 requests with DEPTH=4 and `out_ready=0` → `in_ready` drops after 5 accepted (4 queued + 1 in flight). Releasing `out_ready` drains all results in order with correct values.
- 5/0:
  - Without the macro → quotient 0, one `div_start`.
  - With the macro → quotient 0, `out_dz=1`, no `div_start`.
- `rst` pulsed while in S_WAIT with 2 queued → all outputs 0, `in_ready=1`. The next request, 9/3, returns 3.
- `out_ready` toggled randomly over 50 random operand pairs → every result matches the truncating reference, order is preserved, and there is never more than one `div_start` per `div_done`.
